// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared CPU parameters and hazard scheduler FSM encodings.
package pipe_hazard_ctrl_pkg;
  localparam int WORD = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [1:0] HZ_RUN = 2'd0;
  localparam logic [1:0] HZ_DC_WAIT = 2'd1;
  localparam logic [1:0] HZ_REDIR_PEND = 2'd2;
endpackage

// File: rtl/pipe_hazard_ctrl_perf_cnt.sv
// Enabled event counter: wraps, or saturates at MAX when SAT is set.
module hz_perf_cnt #(
  parameter int W = 32,
  parameter bit SAT = 1'b0,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !(SAT && r_cnt == MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline with deferred
// PC redirect while the ICache is busy.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int DC_TIMEOUT = 1024,
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dcache_busy,
  input  logic                  icache_miss,
  input  logic                  ex_redirect,
  input  logic [WORD-1:0]       ex_target,
  input  logic                  pre_redirect,
  input  logic [WORD-1:0]       pre_target,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] id_rj,
  input  logic [REG_ADDR_W-1:0] id_rk,
  input  logic                  id_use_rj,
  input  logic                  id_use_rk,
  output logic                  pc_stall,
  output logic                  pc_redirect,
  output logic [WORD-1:0]       pc_target,
  output logic                  if1_id_stall,
  output logic                  if1_id_flush,
  output logic                  id_ex_stall,
  output logic                  id_ex_flush,
  output logic                  ex_mem_stall,
  output logic                  mem_wb_flush,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic                  dc_timeout
);
  localparam int DC_W = $clog2(DC_TIMEOUT + 1);

  logic [1:0]      r_state;
  logic [1:0]      w_state_nx;
  logic            r_pend_dc;
  logic [WORD-1:0] r_pend_tgt;
  logic [WORD-1:0] w_pend_tgt_nx;
  logic            r_dc_to;
  logic [DC_W-1:0] w_dc_cnt;

  logic            w_lu;
  logic            w_pend;
  logic            w_want;
  logic            w_issue;
  logic [WORD-1:0] w_tgt;
  logic            w_pc_stall;
  logic            w_if1_stall;
  logic            w_if1_flush;
  logic            w_idex_stall;
  logic            w_idex_flush;
  logic            w_exmem_stall;
  logic            w_memwb_flush;

  assign w_lu = ex_is_load && (ex_rd != '0) &&
                ((id_use_rj && id_rj == ex_rd) ||
                 (id_use_rk && id_rk == ex_rd));

  // A DCache freeze taken from REDIR_PEND remembers the pending target.
  assign w_pend = (r_state == HZ_REDIR_PEND) ||
                  (r_state == HZ_DC_WAIT && r_pend_dc);

  always_comb begin
    w_pc_stall    = 1'b0;
    w_if1_stall   = 1'b0;
    w_if1_flush   = 1'b0;
    w_idex_stall  = 1'b0;
    w_idex_flush  = 1'b0;
    w_exmem_stall = 1'b0;
    w_memwb_flush = 1'b0;
    w_want        = 1'b0;
    w_issue       = 1'b0;
    w_tgt         = r_pend_tgt;
    w_state_nx    = HZ_RUN;
    w_pend_tgt_nx = r_pend_tgt;
    priority case (1'b1)
      dcache_busy: begin
        w_pc_stall    = 1'b1;
        w_if1_stall   = 1'b1;
        w_idex_stall  = 1'b1;
        w_exmem_stall = 1'b1;
        w_memwb_flush = 1'b1;
        w_state_nx    = HZ_DC_WAIT;
      end
      w_pend: begin
        w_if1_flush  = 1'b1;
        w_idex_flush = ex_redirect | w_lu;
        w_want       = 1'b1;
        if (ex_redirect) w_tgt = ex_target;
      end
      ex_redirect: begin
        w_if1_flush  = 1'b1;
        w_idex_flush = 1'b1;
        w_want       = 1'b1;
        w_tgt        = ex_target;
      end
      w_lu: begin
        w_pc_stall   = 1'b1;
        w_if1_stall  = 1'b1;
        w_idex_flush = 1'b1;
      end
      pre_redirect: begin
        w_if1_flush = 1'b1;
        w_want      = 1'b1;
        w_tgt       = pre_target;
      end
      icache_miss: begin
        w_pc_stall  = 1'b1;
        w_if1_flush = 1'b1;
      end
      default: ;
    endcase
    if (w_want) begin
      if (icache_miss) begin
        w_pc_stall    = 1'b1;
        w_state_nx    = HZ_REDIR_PEND;
        w_pend_tgt_nx = w_tgt;
      end else begin
        w_issue = 1'b1;
      end
    end
  end

  // Reset forces bubbles everywhere; flush beats stall per register.
  assign pc_stall     = rst_n & w_pc_stall;
  assign pc_redirect  = rst_n & w_issue;
  assign pc_target    = pc_redirect ? w_tgt : '0;
  assign if1_id_flush = !rst_n | w_if1_flush;
  assign id_ex_flush  = !rst_n | w_idex_flush;
  assign mem_wb_flush = !rst_n | w_memwb_flush;
  assign if1_id_stall = rst_n & w_if1_stall & !if1_id_flush;
  assign id_ex_stall  = rst_n & w_idex_stall & !id_ex_flush;
  assign ex_mem_stall = rst_n & w_exmem_stall;
  assign dc_timeout   = r_dc_to;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= HZ_RUN;
      r_pend_dc  <= 1'b0;
      r_pend_tgt <= '0;
      r_dc_to    <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_pend_dc  <= dcache_busy & w_pend;
      r_pend_tgt <= w_pend_tgt_nx;
      if (dcache_busy && w_dc_cnt >= DC_W'(DC_TIMEOUT - 1)) begin
        r_dc_to <= 1'b1;
      end
    end
  end

  hz_perf_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (pc_stall),
    .i_clr (1'b0),
    .o_cnt (stall_cnt)
  );

  hz_perf_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (if1_id_flush),
    .i_clr (1'b0),
    .o_cnt (flush_cnt)
  );

  hz_perf_cnt #(
    .W   (DC_W),
    .SAT (1'b1),
    .MAX (DC_W'(DC_TIMEOUT))
  ) u_dc_busy_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (dcache_busy),
    .i_clr (!dcache_busy),
    .o_cnt (w_dc_cnt)
  );
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table, directed corner
// sequences and random stimulus against a rule-level model.
module tb_pipe_hazard_ctrl;
  localparam int T = 8;
  localparam int CW = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dcache_busy, icache_miss, ex_redirect, pre_redirect;
  logic [31:0] ex_target, pre_target;
  logic        ex_is_load, id_use_rj, id_use_rk;
  logic [4:0]  ex_rd, id_rj, id_rk;
  logic        pc_stall, pc_redirect;
  logic [31:0] pc_target;
  logic        if1_id_stall, if1_id_flush, id_ex_stall, id_ex_flush;
  logic        ex_mem_stall, mem_wb_flush, dc_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(.DC_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .dcache_busy(dcache_busy), .icache_miss(icache_miss),
    .ex_redirect(ex_redirect), .ex_target(ex_target),
    .pre_redirect(pre_redirect), .pre_target(pre_target),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .id_rj(id_rj), .id_rk(id_rk),
    .id_use_rj(id_use_rj), .id_use_rk(id_use_rk),
    .pc_stall(pc_stall), .pc_redirect(pc_redirect),
    .pc_target(pc_target),
    .if1_id_stall(if1_id_stall), .if1_id_flush(if1_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
    .ex_mem_stall(ex_mem_stall), .mem_wb_flush(mem_wb_flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .dc_timeout(dc_timeout)
  );

  always #5 clk = ~clk;

  // ctrl bits: pc_stall pc_redirect if1s if1f idexs idexf exmems memwbf
  typedef struct packed {
    logic [7:0]  ctrl;
    logic [31:0] tgt;
    logic        latch;
    logic [31:0] latch_tgt;
  } exp_t;

  typedef struct {
    logic       busy, icm, exr, prr, ld;
    logic [4:0] rd, rj, rk;
    logic       urj, urk;
    logic [7:0] ctrl;
    logic [31:0] tgt;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;

  logic        m_pend, m_to;
  logic [31:0] m_tgt;
  int          m_run, m_stall, m_flush;

  function automatic logic [7:0] dut_ctrl();
    return {pc_stall, pc_redirect, if1_id_stall, if1_id_flush,
            id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    m_pend = 1'b0; m_to = 1'b0; m_tgt = '0;
    m_run = 0; m_stall = 0; m_flush = 0;
  endtask

  function automatic exp_t mdl();
    exp_t e;
    logic lu, want;
    logic [31:0] t;
    e = '0; want = 1'b0; t = '0;
    lu = ex_is_load && (ex_rd != 5'd0) &&
         ((id_use_rj && id_rj == ex_rd) ||
          (id_use_rk && id_rk == ex_rd));
    if (dcache_busy) e.ctrl = 8'b1010_1011;
    else if (m_pend) begin
      e.ctrl[4] = 1'b1;
      e.ctrl[2] = ex_redirect || lu;
      want = 1'b1;
      t = ex_redirect ? ex_target : m_tgt;
    end else if (ex_redirect) begin
      e.ctrl[4] = 1'b1; e.ctrl[2] = 1'b1;
      want = 1'b1; t = ex_target;
    end else if (lu) e.ctrl = 8'b1010_0100;
    else if (pre_redirect) begin
      e.ctrl[4] = 1'b1; want = 1'b1; t = pre_target;
    end else if (icache_miss) e.ctrl = 8'b1001_0000;
    if (want && icache_miss) begin
      e.ctrl[7] = 1'b1; e.latch = 1'b1; e.latch_tgt = t;
    end else if (want) begin
      e.ctrl[6] = 1'b1; e.tgt = t;
    end
    return e;
  endfunction

  task automatic m_update(input exp_t e);
    if (dcache_busy) begin
      if (m_run < T) m_run++;
      if (m_run == T) m_to = 1'b1;
    end else begin
      m_run = 0;
      m_pend = e.latch;
      if (e.latch) m_tgt = e.latch_tgt;
    end
    if (e.ctrl[7]) m_stall = (m_stall + 1) % (1 << CW);
    if (e.ctrl[4]) m_flush = (m_flush + 1) % (1 << CW);
  endtask

  task automatic tick_pre();
    exp_t e;
    @(negedge clk);
    e = mdl();
    chk("model ctrl", {24'd0, dut_ctrl()}, {24'd0, e.ctrl});
    chk("model pc_target", pc_target, e.tgt);
    chk("model stall_cnt", {24'd0, stall_cnt}, m_stall);
    chk("model flush_cnt", {24'd0, flush_cnt}, m_flush);
    chk("model dc_timeout", {31'd0, dc_timeout}, {31'd0, m_to});
  endtask

  task automatic tick_post();
    exp_t e;
    e = mdl();
    @(posedge clk);
    m_update(e);
    #1;
  endtask

  task automatic clr_in();
    dcache_busy = 1'b0; icache_miss = 1'b0;
    ex_redirect = 1'b0; pre_redirect = 1'b0;
    ex_target = '0; pre_target = '0;
    ex_is_load = 1'b0; ex_rd = '0; id_rj = '0; id_rk = '0;
    id_use_rj = 1'b0; id_use_rk = 1'b0;
  endtask

  task automatic chk_reset_out(input string nm);
    chk({nm, " ctrl"}, {24'd0, dut_ctrl()}, 32'h15);
    chk({nm, " pc_target"}, pc_target, 32'h0);
    chk({nm, " cnts"}, {16'd0, stall_cnt, flush_cnt}, 32'h0);
    chk({nm, " dc_timeout"}, {31'd0, dc_timeout}, 32'h0);
  endtask

  vec_t tbl[11];
  logic [7:0] sc0;

  initial begin
    tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,8'h00,32'h0};
    tbl[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,5'd5,5'd5,5'd0,1'b1,1'b0,8'hA4,32'h0};
    tbl[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,5'd0,5'd0,5'd0,1'b1,1'b1,8'h00,32'h0};
    tbl[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,5'd5,5'd5,5'd5,1'b0,1'b0,8'h00,32'h0};
    tbl[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,5'd7,5'd3,5'd7,1'b1,1'b1,8'hA4,32'h0};
    tbl[5]  = '{1'b0,1'b0,1'b1,1'b1,1'b1,5'd5,5'd5,5'd0,1'b1,1'b0,8'h54,32'h1c000100};
    tbl[6]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,8'h50,32'h40};
    tbl[7]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,5'd9,5'd9,5'd0,1'b1,1'b0,8'hA4,32'h0};
    tbl[8]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,8'h90,32'h0};
    tbl[9]  = '{1'b1,1'b0,1'b1,1'b0,1'b1,5'd5,5'd5,5'd0,1'b1,1'b0,8'hAB,32'h0};
    tbl[10] = '{1'b0,1'b0,1'b0,1'b0,1'b0,5'd5,5'd5,5'd0,1'b1,1'b0,8'h00,32'h0};

    clr_in();
    m_reset();
    #12;
    chk_reset_out("reset");
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      clr_in();
      dcache_busy = tbl[i].busy; icache_miss = tbl[i].icm;
      ex_redirect = tbl[i].exr; pre_redirect = tbl[i].prr;
      ex_target = 32'h1c000100; pre_target = 32'h40;
      ex_is_load = tbl[i].ld; ex_rd = tbl[i].rd;
      id_rj = tbl[i].rj; id_rk = tbl[i].rk;
      id_use_rj = tbl[i].urj; id_use_rk = tbl[i].urk;
      tick_pre();
      chk($sformatf("vec%0d ctrl", i), {24'd0, dut_ctrl()}, {24'd0, tbl[i].ctrl});
      chk($sformatf("vec%0d pc_target", i), pc_target, tbl[i].tgt);
      tick_post();
    end

    // Deferred redirect: later EX target replaces predictor target.
    clr_in();
    pre_redirect = 1'b1; pre_target = 32'h40; icache_miss = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      ex_redirect = (c == 2); ex_target = 32'h80;
      tick_pre();
      chk($sformatf("pend c%0d stall/flush", c),
          {30'd0, pc_stall, if1_id_flush}, 32'h3);
      chk($sformatf("pend c%0d redirect", c), {31'd0, pc_redirect}, 32'h0);
      tick_post();
    end
    ex_redirect = 1'b0; icache_miss = 1'b0;
    tick_pre();
    chk("pend issue redirect", {31'd0, pc_redirect}, 32'h1);
    chk("pend issue target", pc_target, 32'h80);
    tick_post();
    pre_redirect = 1'b0;
    tick_pre();
    chk("pend done", {31'd0, pc_redirect}, 32'h0);
    tick_post();

    // DCache freeze holds back an EX redirect.
    clr_in();
    dcache_busy = 1'b1; ex_redirect = 1'b1; ex_target = 32'h1c000100;
    for (int c = 1; c <= 4; c++) begin
      tick_pre();
      if (c == 1) sc0 = stall_cnt;
      chk($sformatf("dc c%0d ctrl", c), {24'd0, dut_ctrl()}, 32'hAB);
      tick_post();
    end
    dcache_busy = 1'b0;
    tick_pre();
    chk("dc stall_cnt delta", {24'd0, 8'(stall_cnt - sc0)}, 32'd4);
    chk("dc issue redirect", {31'd0, pc_redirect}, 32'h1);
    chk("dc issue target", pc_target, 32'h1c000100);
    tick_post();

    // Timeout after exactly T busy cycles, then sticky.
    clr_in();
    dcache_busy = 1'b1;
    for (int c = 1; c <= T; c++) begin
      tick_pre();
      chk($sformatf("to c%0d pre", c), {31'd0, dc_timeout}, 32'h0);
      tick_post();
    end
    dcache_busy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick_pre();
      chk($sformatf("to sticky %0d", c), {31'd0, dc_timeout}, 32'h1);
      tick_post();
    end

    // Async reset while a redirect is pending.
    clr_in();
    pre_redirect = 1'b1; pre_target = 32'h1234; icache_miss = 1'b1;
    tick_pre();
    tick_post();
    #1 rst_n = 1'b0;
    m_reset();
    #1;
    chk_reset_out("rst pend");
    #1 rst_n = 1'b1;
    clr_in();
    tick_pre();
    chk("rst pend discarded", {31'd0, pc_redirect}, 32'h0);
    chk("rst pend no stall", {31'd0, pc_stall}, 32'h0);
    tick_post();

    // Random traffic with DCache busy bursts.
    for (int n = 0; n < 3000; n++) begin
      dcache_busy  = ($urandom_range(0, 99) < (dcache_busy ? 85 : 10));
      icache_miss  = ($urandom_range(0, 99) < 35);
      ex_redirect  = ($urandom_range(0, 99) < 15);
      pre_redirect = ($urandom_range(0, 99) < 20);
      ex_target    = $urandom;
      pre_target   = $urandom;
      ex_is_load   = ($urandom_range(0, 99) < 40);
      ex_rd        = 5'($urandom_range(0, 3));
      id_rj        = 5'($urandom_range(0, 3));
      id_rk        = 5'($urandom_range(0, 3));
      id_use_rj    = 1'($urandom_range(0, 1));
      id_use_rk    = 1'($urandom_range(0, 1));
      tick_pre();
      tick_post();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush scheduler for the 5-stage LoongArch32 pipeline (IF1, ID, EX, MEM, WB). It resolves DCache stalls, ICache misses, load-use hazards, and branch redirects from EX and from the ID predictor into per-stage-register stall/flush controls and a single PC redirect. While the ICache is busy it holds any redirect pending, and it keeps hazard performance counters. It drives the stall and flush inputs of IF1_ID, ID_EX, EX_MEM and MEM_WB.

## Interface
- `DC_TIMEOUT`, default 1024: DCache busy cycles before the sticky timeout flag sets.
- `CNT_W`, default 32: performance counter width.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `dcache_busy` in 1: MEM-stage DCache miss in progress.
- `icache_miss` in 1: IF1 fetch not yet valid.
- `ex_redirect` in 1: EX resolved a mispredict.
- `ex_target` in 32: correct PC from EX.
- `pre_redirect` in 1: ID predictor predicts taken.
- `pre_target` in 32: predicted target.
- `ex_is_load` in 1: load in EX.
- `ex_rd` in 5: EX destination register.
- `id_rj` in 5, `id_rk` in 5: ID source registers.
- `id_use_rj` in 1, `id_use_rk` in 1: ID source-register valid bits.
- `pc_stall` out 1: hold PC.
- `pc_redirect` out 1: load PC from `pc_target`.
- `pc_target` out 32: redirect address.
- `if1_id_stall` out 1, `if1_id_flush` out 1: IF1_ID controls.
- `id_ex_stall` out 1, `id_ex_flush` out 1: ID_EX controls.
- `ex_mem_stall` out 1: EX_MEM control.
- `mem_wb_flush` out 1: MEM_WB control.
- `stall_cnt` out CNT_W: cycles with `pc_stall`=1.
- `flush_cnt` out CNT_W: cycles with `if1_id_flush`=1.
- `dc_timeout` out 1: sticky flag.

## Operation
- FSM states: RUN, DC_WAIT, REDIR_PEND. Reset state is RUN.
- Per-cycle priority, highest first:
  1. `dcache_busy`. Stall PC, IF1_ID, ID_EX and EX_MEM; assert `mem_wb_flush`. All redirect inputs are ignored because EX is frozen and re-presents them later. Next state is DC_WAIT, then RUN when `dcache_busy` drops.
  2. `ex_redirect`. Flush IF1_ID and ID_EX; target is `ex_target`. This overrides a load-use hazard and `pre_redirect`.
  3. Load-use. Condition: `ex_is_load` && `ex_rd`≠0 && ((`id_use_rj` && `id_rj`==`ex_rd`) || (`id_use_rk` && `id_rk`==`ex_rd`)). Stall PC and IF1_ID, flush ID_EX. Lasts exactly one cycle per hazard.
  4. `pre_redirect`. Flush IF1_ID; target is `pre_target`.
  5. `icache_miss` alone. Stall PC, flush IF1_ID (bubble).
- Redirect issue:
  - If `icache_miss`=0, drive `pc_redirect`=1 with the target in the same cycle.
  - Otherwise latch the target into `pend_target`, enter REDIR_PEND, and hold `pc_stall`=1.
- REDIR_PEND:
  - Keep flushing IF1_ID every cycle.
  - A new `ex_redirect` overwrites `pend_target`; `pre_redirect` never overwrites it.
  - When `icache_miss`=0, issue `pc_redirect`=1 with `pend_target` and return to RUN.
  - If `dcache_busy` rises in REDIR_PEND, the pending target is kept and rule 1 controls apply; return to REDIR_PEND after.
- A flush always wins over a stall on the same register: the stall output is forced to 0 when the flush output is 1.
- Counters:
  - `stall_cnt` and `flush_cnt` increment by 1 per qualifying cycle and wrap modulo 2^CNT_W.
  - Internal `dc_busy_cnt` clears when `dcache_busy`=0 and saturates at `DC_TIMEOUT`.
  - On reaching `DC_TIMEOUT`, `dc_timeout` sets and stays set until reset.

## Timing
- All stall/flush/redirect outputs are combinational from the inputs and FSM state; stage registers act on the next `posedge clk`.
- Redirect latency: zero cycles when the ICache is idle. Otherwise the redirect issues in the first cycle with `icache_miss`=0.
- Registered state: FSM, `pend_target`, counters, `dc_busy_cnt`, `dc_timeout`.
- Reset (`rst_n`=0, asynchronous): FSM returns to RUN, `pend_target` clears to 0, counters clear to 0, `dc_timeout`=0.
- Output values during reset:
  - Every stall output and `pc_redirect` is 0.
  - `if1_id_flush`=`id_ex_flush`=`mem_wb_flush`=1, so no stale instruction advances.
  - `pc_target`=0.
- Reset mid-REDIR_PEND discards the pending target.

## Structure
- The shared CPU parameter header holds `WORD` (32), `REG_ADDR_W` (5), and the FSM state encodings `HZ_RUN`, `HZ_DC_WAIT` and `HZ_REDIR_PEND`.
- One sub-module, `hz_perf_cnt`: a parameterised wrapping/saturating counter with an enable, instantiated three times (`stall_cnt`, `flush_cnt`, `dc_busy_cnt`).

## Test plan
- Load-use: `ex_is_load`=1, `ex_rd`=5, `id_rj`=5, `id_use_rj`=1. Expect exactly 1 cycle of `pc_stall`=`if1_id_stall`=`id_ex_flush`=1. With `ex_rd`=0, expect no stall.
- EX redirect beats load-use and predictor: `ex_redirect`=1 (`ex_target`=0x1c000100), `pre_redirect`=1, plus a load-use hazard. Expect `pc_redirect`=1, `pc_target`=0x1c000100, `if1_id_flush`=`id_ex_flush`=1, `pc_stall`=0.
- Pending redirect: `pre_redirect` with `pre_target`=0x40 while `icache_miss`=1 for 3 cycles, with `ex_redirect` to 0x80 in the 2nd cycle. Expect `pc_stall`=1 and IF1_ID flushed throughout, then `pc_redirect`=1, `pc_target`=0x80 on the cycle `icache_miss` falls.
- DCache stall: `dcache_busy`=1 for 4 cycles with `ex_redirect`=1. Expect all stalls=1, `mem_wb_flush`=1, `pc_redirect`=0 for 4 cycles. Redirect issues in cycle 5. `stall_cnt` increases by 4 during the busy cycles.
- Timeout: `DC_TIMEOUT`=8, `dcache_busy` held 8 cycles. Expect `dc_timeout`=1 from then on and staying set after `dcache_busy` drops.
- Async reset in REDIR_PEND: pulse `rst_n` low between clock edges. Expect RUN, counters 0, no `pc_redirect` after release, and the pending target discarded.
